mod_updown_counter: RTL

Parametrised synchronous up/down counter. It is the next generation of the team's 8-bit T-flip-flop ripple counter and replaces it wherever a counter feeds other clocked logic. All bits change on a single clock edge, so there is no ripple settling and no decode glitches. Adds:
- programmable modulus
- direction control
- parallel load and synchronous clear
- wrap or saturate mode
- a terminal-count output for cascading

---
 rtl/mod_updown_counter.sv | 110 +++++++++++
 1 files changed

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: synchronous up/down counter with programmable modulus,
// parallel load, synchronous clear, wrap/saturate mode and a terminal-count
// output for cascading. Every state bit updates on the same clock edge.
module mod_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 2**WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  // Range limits are held one bit wider than the count so that
  // MODULUS = 2**WIDTH is representable in the compares.
  localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_X = MOD_X - ONE_X;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic             wrap_r;
  logic             wrap_next_s;
  logic             err_r;
  logic             err_next_s;
  logic [WIDTH:0]   q_ext_s;
  logic [WIDTH:0]   din_ext_s;
  logic [WIDTH-1:0] q_inc_s;
  logic [WIDTH-1:0] q_dec_s;
  logic             at_max_s;
  logic             at_zero_s;

  assign q_ext_s   = {1'b0, q_r};
  assign din_ext_s = {1'b0, din};
  assign q_inc_s   = q_r + ONE_X[WIDTH-1:0];
  assign q_dec_s   = q_r - ONE_X[WIDTH-1:0];
  assign at_max_s  = (q_ext_s == MAX_X);
  assign at_zero_s = (q_r == {WIDTH{1'b0}});

  // Next-state selection: clr beats load, load beats count enable.
  always_comb begin
    q_next_s    = q_r;
    wrap_next_s = 1'b0;
    err_next_s  = err_r;
    if (clr) begin
      q_next_s   = {WIDTH{1'b0}};
      err_next_s = 1'b0;
    end else if (load) begin
      if (din_ext_s >= MOD_X) begin
        // Out-of-range load clamps to the top of the range and is remembered.
        q_next_s   = MAX_X[WIDTH-1:0];
        err_next_s = 1'b1;
      end else begin
        q_next_s = din;
      end
    end else if (en) begin
      if (up) begin
        if (!at_max_s) begin
          q_next_s = q_inc_s;
        end else if (SATURATE) begin
          q_next_s = q_r;
        end else begin
          q_next_s    = {WIDTH{1'b0}};
          wrap_next_s = 1'b1;
        end
      end else begin
        if (!at_zero_s) begin
          q_next_s = q_dec_s;
        end else if (SATURATE) begin
          q_next_s = q_r;
        end else begin
          q_next_s    = MAX_X[WIDTH-1:0];
          wrap_next_s = 1'b1;
        end
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // State register; reset discards any in-flight update immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r    <= {WIDTH{1'b0}};
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      wrap_r <= wrap_next_s;
      err_r  <= err_next_s;
    end
  end

  assign q    = q_r;
  assign wrap = wrap_r;
  assign err  = err_r;

  // Terminal count stays combinational so a cascaded stage sees it in the
  // same cycle it samples its enable.
  assign tc = en & (up ? at_max_s : at_zero_s);

endmodule
